// File: rtl/life_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : life_sequencer
//  Purpose  : Seeds the Game of Life cell array, then advances it one
//             generation per enable pulse. Optional macro LIFE_STASIS_HALT_EN
//             stops the sequencer once a generation produces no change.
//  Revision : 1.0 - initial release
// ============================================================================
module life_sequencer #(
    parameter int TICKS_PER_GEN = 4,
    parameter int SEED_CYCLES   = 2,
    parameter int GEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             clear,
    input  logic             any_change,
    output logic             cells_rst,
    output logic             cells_ena,
    output logic [GEN_W-1:0] generation,
    output logic             running,
    output logic             halted
);

    localparam int c_tick_w = (TICKS_PER_GEN > 2) ? $clog2(TICKS_PER_GEN) : 1;
    localparam int c_seed_w = $clog2(SEED_CYCLES + 1);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICKS_PER_GEN - 1);
    localparam logic [c_seed_w-1:0] c_seed_last = c_seed_w'(SEED_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SEED    = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_RUNNING = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_seed_w-1:0] r_seed_cnt;
    logic [c_seed_w-1:0] w_seed_cnt_nxt;
    logic [c_tick_w-1:0] r_tick;
    logic [c_tick_w-1:0] w_tick_nxt;
    logic                r_step_pend;
    logic                w_step_pend_nxt;
    logic                r_cells_rst;
    logic                r_cells_ena;
    logic                w_ena_nxt;
    logic [GEN_W-1:0]    r_gen;
    logic                r_running;
    logic                w_stasis;

`ifdef LIFE_STASIS_HALT_EN
    // any_change is meaningful only while the cells are being enabled
    assign w_stasis = r_cells_ena & ~any_change;
`else
    logic w_unused_any_change;
    assign w_unused_any_change = any_change;
    assign w_stasis            = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_seed_cnt_nxt  = r_seed_cnt;
        w_tick_nxt      = r_tick;
        w_step_pend_nxt = 1'b0;
        w_ena_nxt       = 1'b0;
        if (clear) begin
            w_state_nxt    = ST_SEED;
            w_seed_cnt_nxt = '0;
            w_tick_nxt     = '0;
        end else begin
            case (r_state)
                ST_SEED: begin
                    w_tick_nxt = '0;
                    if (r_seed_cnt == c_seed_last) begin
                        w_state_nxt = ST_PAUSED;
                    end else begin
                        w_seed_cnt_nxt = r_seed_cnt + c_seed_w'(1);
                    end
                end
                ST_PAUSED: begin
                    // step is registered once so the pulse lands one cycle later
                    w_ena_nxt = r_step_pend;
                    if (run) begin
                        w_state_nxt = ST_RUNNING;
                        w_tick_nxt  = '0;
                    end else if (step) begin
                        w_step_pend_nxt = 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (!run) begin
                        w_state_nxt = ST_PAUSED;
                        w_tick_nxt  = '0;
                    end else if (r_tick == c_tick_last) begin
                        w_tick_nxt = '0;
                        w_ena_nxt  = 1'b1;
                    end else begin
                        w_tick_nxt = r_tick + c_tick_w'(1);
                    end
                end
                default: begin
                    w_tick_nxt = '0;
                end
            endcase
            if (w_stasis && (r_state == ST_PAUSED || r_state == ST_RUNNING)) begin
                w_state_nxt     = ST_HALTED;
                w_tick_nxt      = '0;
                w_ena_nxt       = 1'b0;
                w_step_pend_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_SEED;
            r_seed_cnt  <= '0;
            r_tick      <= '0;
            r_step_pend <= 1'b0;
            r_cells_rst <= 1'b1;
            r_cells_ena <= 1'b0;
            r_gen       <= '0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_seed_cnt  <= w_seed_cnt_nxt;
            r_tick      <= w_tick_nxt;
            r_step_pend <= w_step_pend_nxt;
            r_cells_rst <= (w_state_nxt == ST_SEED);
            r_cells_ena <= w_ena_nxt;
            r_running   <= (w_state_nxt == ST_RUNNING);
            if (clear) begin
                r_gen <= '0;
            end else if (r_cells_ena) begin
                r_gen <= r_gen + GEN_W'(1);
            end
        end
    end

`ifdef LIFE_STASIS_HALT_EN
    logic r_halted;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= (w_state_nxt == ST_HALTED);
        end
    end
    assign halted = r_halted;
`else
    assign halted = 1'b0;
`endif

    assign cells_rst  = r_cells_rst;
    assign cells_ena  = r_cells_ena;
    assign generation = r_gen;
    assign running    = r_running;

endmodule
`default_nettype wire

// File: tb/tb_life_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_life_sequencer
//  Purpose  : Directed and random stimulus for life_sequencer, compared each
//             cycle with a schedule-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_life_sequencer;

    localparam int TICKS = 4;
    localparam int SEEDC = 2;
    localparam int GW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          clear = 1'b0;
    logic          any_change = 1'b1;
    logic          cells_rst;
    logic          cells_ena;
    logic [GW-1:0] generation;
    logic          running;
    logic          halted;

    life_sequencer #(
        .TICKS_PER_GEN(TICKS),
        .SEED_CYCLES  (SEEDC),
        .GEN_W        (GW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .clear     (clear),
        .any_change(any_change),
        .cells_rst (cells_rst),
        .cells_ena (cells_ena),
        .generation(generation),
        .running   (running),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: modes 0 SEED, 1 PAUSED, 2 RUNNING, 3 HALTED.
    // Running pulses are scheduled by distance from the entry edge.
    int cyc         = 0;
    int m_mode      = 0;
    int m_seen      = 0;
    int m_run_start = 0;
    int m_step_due  = -1;
    bit e_rst       = 1'b1;
    bit e_ena       = 1'b0;
    bit e_run       = 1'b0;
    bit e_halt      = 1'b0;
    int e_gen       = 0;

    task automatic model_edge();
        bit prev_ena;
        bit fire;
        prev_ena = e_ena;
        fire     = 1'b0;
        cyc++;
        if (!rst || clear) begin
            m_mode     = 0;
            m_seen     = 0;
            m_step_due = -1;
            e_gen      = 0;
        end else begin
            if (prev_ena) e_gen = (e_gen + 1) % (1 << GW);
            case (m_mode)
                0: begin
                    m_seen++;
                    if (m_seen == SEEDC) m_mode = 1;
                end
                1: begin
                    if (m_step_due == cyc) begin
                        fire       = 1'b1;
                        m_step_due = -1;
                    end
                    if (run) begin
                        m_mode      = 2;
                        m_run_start = cyc;
                    end else if (step) begin
                        m_step_due = cyc + 1;
                    end
                end
                2: begin
                    if (!run) m_mode = 1;
                    else if ((cyc - m_run_start) % TICKS == 0) fire = 1'b1;
                end
                default: ;
            endcase
`ifdef LIFE_STASIS_HALT_EN
            if (prev_ena && !any_change && (m_mode == 1 || m_mode == 2)) begin
                m_mode     = 3;
                fire       = 1'b0;
                m_step_due = -1;
            end
`endif
        end
        e_ena  = fire;
        e_rst  = (m_mode == 0);
        e_run  = (m_mode == 2);
        e_halt = (m_mode == 3);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check($sformatf("cells_rst@%0d", cyc), 32'(cells_rst), 32'(e_rst));
        check($sformatf("cells_ena@%0d", cyc), 32'(cells_ena), 32'(e_ena));
        check($sformatf("generation@%0d", cyc), 32'(generation), 32'(e_gen));
        check($sformatf("running@%0d", cyc), 32'(running), 32'(e_run));
        check($sformatf("halted@%0d", cyc), 32'(halted), 32'(e_halt));
    endtask

    initial begin
        bit prev_step;

        // reset, then release with run low
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();

        // free run, then pause
        run = 1'b1;
        repeat (20) tick();
        run = 1'b0;
        repeat (6) tick();

        // single step while paused
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (4) tick();

        // run and step together, then stray steps while running
        run  = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step = (i % 2 == 1);
            tick();
        end
        step = 1'b0;

        // long run to wrap the generation counter
        repeat (17 * TICKS + 2) tick();

        // clear on a cycle where a pulse is due
        for (int i = 0; i < TICKS && ((cyc + 1 - m_run_start) % TICKS != 0); i++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (4) tick();

        // reset mid-run
        run = 1'b1;
        repeat (7) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run = 1'b0;
        repeat (4) tick();

        // stasis on the third pulse, then run/step attempts and clear
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            any_change = !(e_ena && e_gen == 2);
            tick();
        end
        any_change = 1'b1;
        run        = 1'b0;
        step       = 1'b1;
        tick();
        step = 1'b0;
        run  = 1'b1;
        repeat (3) tick();
        run   = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (4) tick();

        // random traffic
        prev_step = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 16 == 0) run = ~run;
            step       = !prev_step && ($urandom % 6 == 0);
            prev_step  = step;
            clear      = ($urandom % 50 == 0);
            rst        = ($urandom % 150 != 0);
            any_change = ($urandom % 10 != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
